// File: rtl/fir_channel_arbiter_if.sv
// fir_channel_arbiter_if: channel request/result bus plus filter handshake for the arbiter
interface fir_channel_arbiter_if;
  logic        req0;
  logic        req1;
  logic [15:0] sample0;
  logic [15:0] sample1;
  logic        modwait;
  logic [15:0] fir_out;
  logic        err;
  logic [15:0] sample_data;
  logic        data_ready;
  logic        ack0;
  logic        ack1;
  logic [15:0] result_data;
  logic        result_ch;
  logic        result_valid;
  logic        result_err;
  logic        busy;
  modport master (
    input  req0, req1, sample0, sample1, modwait, fir_out, err,
    output sample_data, data_ready, ack0, ack1, result_data, result_ch, result_valid, result_err, busy
  );
  modport slave (
    output req0, req1, sample0, sample1, modwait, fir_out, err,
    input  sample_data, data_ready, ack0, ack1, result_data, result_ch, result_valid, result_err, busy
  );
endinterface

// File: rtl/fir_channel_arbiter.sv
// fir_channel_arbiter: round-robin two-channel front end sharing one FIR filter, with handshake timeouts
module fir_channel_arbiter #(
  parameter int TMO_ISSUE = 15,
  parameter int TMO_BUSY  = 63
) (
  input logic                   clk,
  input logic                   n_rst,
  fir_channel_arbiter_if.master bus
);
  localparam int CW = $clog2((TMO_BUSY > TMO_ISSUE ? TMO_BUSY : TMO_ISSUE) + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant_q, grant_d, last_q, last_d;
  logic [15:0]   sample_q, sample_d, rdata_q, rdata_d;
  logic          rerr_q, rerr_d, rch_q, rch_d;
  logic          dr_q, ack0_q, ack1_q, valid_q, busy_q;
  // next state: grant in IDLE, hold data_ready until modwait, wait for modwait low, one-cycle DONE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    last_d   = last_q;
    sample_d = sample_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    rch_d    = rch_q;
    case (state_q)
      IDLE:
        if (bus.req0 || bus.req1) begin
          grant_d  = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          sample_d = grant_d ? bus.sample1 : bus.sample0;
          cnt_d    = '0;
          state_d  = ISSUE;
        end
      ISSUE:
        if (bus.modwait) begin
          state_d = BUSY;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TMO_ISSUE - 1)) begin
          state_d = DONE;
          rdata_d = '0;
          rerr_d  = 1'b1;
          rch_d   = grant_q;
        end else
          cnt_d = cnt_q + 1'b1;
      BUSY:
        if (!bus.modwait) begin
          state_d = DONE;
          rdata_d = bus.fir_out;
          rerr_d  = bus.err;
          rch_d   = grant_q;
        end else if (cnt_q == CW'(TMO_BUSY - 1)) begin
          state_d = DONE;
          rdata_d = '0;
          rerr_d  = 1'b1;
          rch_d   = grant_q;
        end else
          cnt_d = cnt_q + 1'b1;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        last_d  = grant_q;
      end
    endcase
  end
  // state and registered outputs, all derived from the next state so they line up with it
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      sample_q <= '0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      rch_q    <= 1'b0;
      dr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      sample_q <= sample_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      rch_q    <= rch_d;
      dr_q     <= state_d == ISSUE;
      ack0_q   <= state_d == DONE && !grant_d;
      ack1_q   <= state_d == DONE && grant_d;
      valid_q  <= state_d == DONE;
      busy_q   <= state_d != IDLE;
    end
  assign bus.sample_data  = sample_q;
  assign bus.data_ready   = dr_q;
  assign bus.ack0         = ack0_q;
  assign bus.ack1         = ack1_q;
  assign bus.result_data  = rdata_q;
  assign bus.result_ch    = rch_q;
  assign bus.result_valid = valid_q;
  assign bus.result_err   = rerr_q;
  assign bus.busy         = busy_q;
endmodule
